// File: rtl/pwm_pulse_gen.sv
// rtl/pwm_pulse_gen.sv - pattern-masked PWM pulse train generator
//
// Ports:
//   sys_clk    in   single clock
//   sys_rst_n  in   asynchronous active-low reset
//   start      in   one-cycle request to launch a train
//   stop       in   one-cycle abort request (wins over start)
//   period     in   PWM period in clocks (must be >= 2)
//   high_cnt   in   high time per enabled period in clocks
//   pulse_num  in   periods to emit, 0 = continuous
//   pattern    in   per-period enable mask, LSB first
//   pwm_out    out  registered PWM output
//   pwm_busy   out  high while a train is running
//   pwm_valid  out  one-cycle pulse on normal completion
//   cfg_err    out  one-cycle pulse when a start is rejected
module pwm_pulse_gen #(
  parameter int _PAT_WIDTH = 32,
  parameter int _CNT_WIDTH = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [_CNT_WIDTH-1:0] period,
  input  logic [_CNT_WIDTH-1:0] high_cnt,
  input  logic [7:0]            pulse_num,
  input  logic [_PAT_WIDTH-1:0] pattern,
  output logic                  pwm_out,
  output logic                  pwm_busy,
  output logic                  pwm_valid,
  output logic                  cfg_err
);

  localparam int PIW = (_PAT_WIDTH > 1) ? $clog2(_PAT_WIDTH) : 1;
  localparam logic [PIW-1:0] PAT_LAST = PIW'(_PAT_WIDTH - 1);
  localparam logic [_CNT_WIDTH-1:0] CNT_ONE = _CNT_WIDTH'(1);
  localparam logic [_CNT_WIDTH-1:0] CNT_TWO = _CNT_WIDTH'(2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            state;
  logic [_CNT_WIDTH-1:0] per_q;
  logic [_CNT_WIDTH-1:0] high_q;
  logic [7:0]            num_q;
  logic [_PAT_WIDTH-1:0] pat_q;
  logic [_CNT_WIDTH-1:0] phase;
  logic [7:0]            idx;
  logic [PIW-1:0]        pat_idx;

  logic                  period_end;
  logic                  last_period;
  logic [_CNT_WIDTH-1:0] phase_nxt;
  logic [7:0]            idx_nxt;
  logic [PIW-1:0]        pat_idx_nxt;
  logic                  out_nxt;

  always_comb begin
    period_end  = (phase == per_q - CNT_ONE);
    last_period = (num_q != 8'd0) && (idx == num_q - 8'd1);
    phase_nxt   = period_end ? '0 : phase + CNT_ONE;
    // idx wraps freely at 256 in continuous mode; the pattern pointer keeps
    // its own wrap at the mask width so non power-of-two widths still work.
    idx_nxt     = period_end ? idx + 8'd1 : idx;
    pat_idx_nxt = pat_idx;
    if (period_end) begin
      pat_idx_nxt = (pat_idx == PAT_LAST) ? '0 : pat_idx + PIW'(1);
    end
    out_nxt     = (phase_nxt < high_q) && pat_q[pat_idx_nxt];
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= S_IDLE;
      per_q     <= '0;
      high_q    <= '0;
      num_q     <= '0;
      pat_q     <= '0;
      phase     <= '0;
      idx       <= '0;
      pat_idx   <= '0;
      pwm_out   <= 1'b0;
      pwm_busy  <= 1'b0;
      pwm_valid <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      pwm_valid <= 1'b0;
      cfg_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            if (period < CNT_TWO) begin
              cfg_err <= 1'b1;
            end else begin
              per_q    <= period;
              high_q   <= high_cnt;
              num_q    <= pulse_num;
              pat_q    <= pattern;
              phase    <= '0;
              idx      <= '0;
              pat_idx  <= '0;
              state    <= S_RUN;
              pwm_busy <= 1'b1;
              // Phase 0 of period 0 is driven straight from the inputs so
              // the first high level appears one cycle after start.
              pwm_out  <= (high_cnt != '0) && pattern[0];
            end
          end
        end
        S_RUN: begin
          if (stop) begin
            state    <= S_IDLE;
            pwm_busy <= 1'b0;
            pwm_out  <= 1'b0;
          end else if (period_end && last_period) begin
            state     <= S_DONE;
            pwm_busy  <= 1'b0;
            pwm_out   <= 1'b0;
            pwm_valid <= 1'b1;
          end else begin
            phase   <= phase_nxt;
            idx     <= idx_nxt;
            pat_idx <= pat_idx_nxt;
            pwm_out <= out_nxt;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          pwm_busy <= 1'b0;
          pwm_out  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_pulse_gen.sv
// tb/tb_pwm_pulse_gen.sv - scoreboard bench for pwm_pulse_gen
module tb_pwm_pulse_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] period = '0;
  logic [15:0] high_cnt = '0;
  logic [7:0]  pulse_num = '0;
  logic [31:0] pattern = '0;
  logic        pwm_out, pwm_busy, pwm_valid, cfg_err;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  // expected {pwm_out, pwm_busy, pwm_valid, cfg_err} after each clock edge
  logic [3:0] exp_q[$];

  // reference model: a train is expanded into its whole future waveform
  logic [3:0] plan[$];
  bit         cont = 0;
  bit         last_valid = 0;
  int         m_per, m_hi, next_p;
  logic [31:0] m_pat;

  pwm_pulse_gen #(._PAT_WIDTH(32), ._CNT_WIDTH(16)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start), .stop(stop),
    .period(period), .high_cnt(high_cnt), .pulse_num(pulse_num),
    .pattern(pattern), .pwm_out(pwm_out), .pwm_busy(pwm_busy),
    .pwm_valid(pwm_valid), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got out/busy/valid/err=%b required %b", name, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [3:0] e;
      e = exp_q.pop_front();
      chk("wave", {pwm_out, pwm_busy, pwm_valid, cfg_err}, e);
    end
  end

  task automatic add_period();
    for (int ph = 0; ph < m_per; ph++)
      plan.push_back({(ph < m_hi) && m_pat[next_p % 32], 1'b1, 1'b0, 1'b0});
    next_p++;
  endtask

  // drive one cycle, let the edge happen, record what the model expects
  task automatic step(input bit st, input bit sp, input int per, input int hi,
                      input int pn, input logic [31:0] pat);
    logic [3:0] e;
    start = st; stop = sp; period = 16'(per); high_cnt = 16'(hi);
    pulse_num = 8'(pn); pattern = pat;
    @(posedge clk);
    cyc++;
    if (plan.size() > 0) begin
      if (sp) begin
        plan.delete(); cont = 0; e = 4'b0000;
      end else begin
        if (cont && plan.size() <= m_per) add_period();
        e = plan.pop_front();
      end
    end else if (!last_valid && st && !sp) begin
      if (per < 2) e = 4'b0001;
      else begin
        m_per = per; m_hi = hi; m_pat = pat; next_p = 0;
        cont = (pn == 0);
        if (cont) add_period();
        else begin
          repeat (pn) add_period();
          plan.push_back(4'b0010);
        end
        e = plan.pop_front();
      end
    end else e = 4'b0000;
    last_valid = e[1];
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(0, 0, $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 9), $urandom());
  endtask

  task automatic start_during(input int n);
    for (int i = 0; i < n; i++)
      step(1, 0, $urandom_range(2, 40), $urandom_range(0, 40), $urandom_range(0, 9), $urandom());
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {pwm_out, pwm_busy, pwm_valid, cfg_err}, 4'b0000);
    rst_n = 1'b1;

    // accepted on the first edge after release
    step(1, 0, 10, 3, 4, 32'hFFFF_FFFF);
    idle(45);
    step(1, 0, 8, 4, 4, 32'h0000_0005);
    idle(40);
    step(1, 0, 1, 1, 2, 32'hFFFF_FFFF);
    step(1, 0, 0, 1, 2, 32'hFFFF_FFFF);
    idle(5);
    step(1, 0, 5, 2, 0, 32'hFFFF_FFFF);
    idle(22);
    step(0, 1, 5, 2, 0, 32'hFFFF_FFFF);
    idle(5);
    step(1, 1, 6, 2, 2, 32'hFFFF_FFFF);
    idle(3);
    step(1, 0, 6, 2, 2, 32'h0000_0003);
    start_during(16);
    idle(4);
    // high_cnt 0 and high_cnt >= period, pattern wrap past 32 periods
    step(1, 0, 4, 0, 3, 32'hFFFF_FFFF);
    idle(15);
    step(1, 0, 3, 7, 3, 32'h0000_0005);
    idle(12);
    step(1, 0, 2, 1, 40, 32'h8000_0001);
    idle(85);
    // stop exactly on the final period end
    step(1, 0, 3, 2, 2, 32'hFFFF_FFFF);
    idle(5);
    step(0, 1, 3, 2, 2, 32'hFFFF_FFFF);
    idle(3);

    // asynchronous reset mid-period while pwm_out is high
    step(1, 0, 20, 20, 2, 32'hFFFF_FFFF);
    idle(3);
    #5;
    chk("pre_reset_high", {pwm_out, pwm_busy, pwm_valid, cfg_err}, 4'b1100);
    rst_n = 1'b0;
    #1;
    chk("async_reset", {pwm_out, pwm_busy, pwm_valid, cfg_err}, 4'b0000);
    plan.delete(); cont = 0; last_valid = 0;
    @(posedge clk); @(posedge clk); #1;
    chk("held_reset", {pwm_out, pwm_busy, pwm_valid, cfg_err}, 4'b0000);
    rst_n = 1'b1;
    step(1, 0, 10, 3, 2, 32'hFFFF_FFFF);
    idle(25);

    // randomized traffic with inputs churning during trains
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 9), $urandom_range(0, 11), $urandom_range(0, 4), $urandom());
    step(0, 1, 5, 1, 1, 32'h0);
    idle(3);

    @(negedge clk); @(negedge clk); #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, required 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pwm_pulse_gen.md
PWM_PULSE_GEN -- requirements
Module: pwm_pulse_gen

Interface
REQ-001 SHALL have parameter _PAT_WIDTH, default 32: pattern mask width, one bit per period.
REQ-002 SHALL have parameter _CNT_WIDTH, default 16: period and high-time counter width.
REQ-003 SHALL have port sys_clk, input, 1: single clock for all logic.
REQ-004 SHALL have port sys_rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1: one-cycle request to launch a pulse train.
REQ-006 SHALL have port stop, input, 1: one-cycle abort request.
REQ-007 SHALL have port period, input, _CNT_WIDTH: PWM period in clocks.
REQ-008 SHALL have port high_cnt, input, _CNT_WIDTH: high time per enabled period in clocks.
REQ-009 SHALL have port pulse_num, input, 8: number of periods to emit; 0 means continuous.
REQ-010 SHALL have port pattern, input, _PAT_WIDTH: per-period enable mask, LSB first.
REQ-011 SHALL have port pwm_out, output, 1: registered PWM output.
REQ-012 SHALL have port pwm_busy, output, 1: high while a train is running.
REQ-013 SHALL have port pwm_valid, output, 1: one-cycle pulse on normal train completion.
REQ-014 SHALL have port cfg_err, output, 1: one-cycle pulse when a start is rejected.

Function
REQ-015 SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-016 In IDLE, a start with stop low SHALL latch period, high_cnt, pulse_num and pattern, then move to RUN on the next edge.
REQ-017 A start with period < 2 SHALL be rejected: the FSM stays in IDLE and cfg_err pulses high for 1 cycle on the following cycle.
REQ-018 Input changes while in RUN SHALL have no effect; only the latched copies are used.
REQ-019 pwm_busy SHALL rise on the cycle after the accepted start and stay high for the whole of RUN.
REQ-020 The phase counter SHALL run from 0 to period-1, then wrap to 0 and advance the period index.
REQ-021 For each period, pwm_out SHALL be 1 when phase < high_cnt and the pattern bit at (period index mod _PAT_WIDTH) is 1; otherwise it SHALL be 0.
REQ-022 The first pwm_out high SHALL appear on the cycle after the accepted start (latency 1).
REQ-023 high_cnt = 0 SHALL give constant 0; high_cnt >= period SHALL give constant 1 in every enabled period.
REQ-024 The pattern index SHALL wrap from _PAT_WIDTH-1 to 0.
REQ-025 Masked periods SHALL still count toward pulse_num.
REQ-026 When pulse_num > 0, at the end of period pulse_num-1 the FSM SHALL move to DONE.
REQ-027 In DONE, pwm_valid SHALL be 1 for exactly 1 cycle, pwm_busy and pwm_out SHALL be 0, and the FSM SHALL return to IDLE on the next edge.
REQ-028 When pulse_num = 0, the train SHALL run until stop and SHALL never assert pwm_valid.
REQ-029 A stop in RUN SHALL force pwm_out and pwm_busy to 0 on the next cycle and return the FSM to IDLE, with no pwm_valid.
REQ-030 If start and stop are high in the same cycle, stop SHALL win and the start SHALL be ignored.
REQ-031 A start while in RUN or DONE SHALL be ignored and SHALL NOT pulse cfg_err.
REQ-032 A stop on the same cycle as the final period end SHALL abort the train, with no pwm_valid.
REQ-033 The period index counter SHALL be 8 bits wide and SHALL saturate-free wrap in continuous mode.

Reset
REQ-034 While sys_rst_n is low, the block SHALL asynchronously force state IDLE and pwm_out = pwm_busy = pwm_valid = cfg_err = 0, and clear all counters and latched configuration.
REQ-035 Reset asserted mid-train SHALL abort the train with no pwm_valid.
REQ-036 After reset release, the block SHALL accept a start on the first clock edge.

Verification
REQ-037 Scenario: period=10, high_cnt=3, pulse_num=4, pattern=all 1s -> 4 pulses each 3 high / 7 low; busy high for 40 cycles; valid high 1 cycle after the last low.
REQ-038 Scenario: pattern=0b0101, pulse_num=4, period=8, high_cnt=4 -> pulses only in periods 0 and 2; busy high for 32 cycles; one valid.
REQ-039 Scenario: period=1 start -> cfg_err pulses 1 cycle; busy stays 0; pwm_out stays 0.
REQ-040 Scenario: pulse_num=0, period=5, high_cnt=2, stop at cycle 23 -> pwm_out and busy are 0 at cycle 24; no valid.
REQ-041 Scenario: start and stop in the same cycle in IDLE -> no activity; a second start during RUN leaves the waveform unchanged.
REQ-042 Scenario: sys_rst_n pulled low mid-period with pwm_out=1 -> all outputs 0 immediately, without waiting for a clock edge; a new start after release runs normally.
